// File: rtl/axi_to_apb_bridge_if.sv
// Bundle of the AXI write channels and APB master signals seen by the bridge.
// The slave modport is the bridge's view; master is the AXI-side driver.
interface axi_to_apb_bridge_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wvalid;
  logic                  wready;
  logic                  bvalid;
  logic                  bready;
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;

  modport master (
    output awaddr, awvalid, wdata, wvalid, bready,
    input  awready, wready, bvalid, PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    input  awaddr, awvalid, wdata, wvalid, bready,
    output awready, wready, bvalid, PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/axi_to_apb_bridge.sv
// Write-only bridge: one AW starts a fixed-length incrementing burst, each W beat
// becomes an APB setup+access pair, and a single B response closes the burst.
module axi_to_apb_bridge #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BURST_LEN  = 4,
  parameter int unsigned ADDR_INC   = 4
) (
  input logic               clk,
  input logic               rst,
  axi_to_apb_bridge_if.slave bus
);

  localparam int unsigned CntW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  typedef enum logic [2:0] {StIdle, StWdata, StSetup, StAccess, StResp} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [CntW-1:0]       beat_q, beat_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  bvalid_q, bvalid_d;
  logic                  last_beat;

  assign last_beat = (beat_q == CntW'(BURST_LEN - 1));

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    beat_d      = beat_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    bvalid_d    = bvalid_q;
    bus.awready = 1'b0;
    bus.wready  = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Ready mirrors valid so it is never raised speculatively.
        bus.awready = bus.awvalid & ~rst;
        if (bus.awvalid) begin
          addr_d  = bus.awaddr;
          beat_d  = '0;
          state_d = StWdata;
        end
      end
      StWdata: begin
        bus.wready = bus.wvalid & ~rst;
        if (bus.wvalid) begin
          paddr_d   = addr_q;
          pwdata_d  = bus.wdata;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = StSetup;
        end
      end
      StSetup: begin
        penable_d = 1'b1;
        state_d   = StAccess;
      end
      StAccess: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        addr_d    = addr_q + ADDR_WIDTH'(ADDR_INC);
        beat_d    = beat_q + CntW'(1);
        if (last_beat) begin
          bvalid_d = 1'b1;
          state_d  = StResp;
        end else begin
          state_d = StWdata;
        end
      end
      StResp: begin
        if (bus.bready) begin
          bvalid_d = 1'b0;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      beat_q    <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      bvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      beat_q    <= beat_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      bvalid_q  <= bvalid_d;
    end
  end

  // Writes only, so PWRITE simply tracks PSEL.
  assign bus.PSEL    = psel_q;
  assign bus.PWRITE  = psel_q;
  assign bus.PENABLE = penable_q;
  assign bus.PADDR   = paddr_q;
  assign bus.PWDATA  = pwdata_q;
  assign bus.bvalid  = bvalid_q;

endmodule

// File: tb/tb_axi_to_apb_bridge.sv
// Randomized bench for axi_to_apb_bridge: a transaction-timing model predicts every
// output each cycle, and directed bursts pin the observed APB addresses to literals.
module tb_axi_to_apb_bridge;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BL = 4;
  localparam int unsigned AI = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_to_apb_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi_to_apb_bridge #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .BURST_LEN (BL),
    .ADDR_INC  (AI)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a burst is outstanding from the AW handshake to the B handshake; each
  // W handshake is followed by one setup cycle and one access cycle.
  bit          m_started = 1'b0;
  bit          m_busy    = 1'b0;
  int          m_beats   = 0;
  int          m_since   = 3;   // edges since last W handshake, saturating at 3
  logic [31:0] m_base    = '0;
  logic [31:0] m_addr    = '0;
  logic [31:0] m_data    = '0;

  function automatic bit exp_awready();
    return !rst && !m_busy && bus.awvalid;
  endfunction
  function automatic bit exp_wready();
    return !rst && m_busy && (m_beats < BL) && (m_since >= 3) && bus.wvalid;
  endfunction
  function automatic bit exp_bvalid();
    return m_busy && (m_beats == BL) && (m_since >= 3);
  endfunction

  always @(posedge clk) begin
    if (rst) m_started <= 1'b1;
    if (rst) begin
      m_busy  <= 1'b0;
      m_since <= 3;
      m_addr  <= '0;
      m_data  <= '0;
    end else begin
      if (exp_awready()) begin
        m_busy  <= 1'b1;
        m_base  <= bus.awaddr;
        m_beats <= 0;
      end
      if (exp_wready()) begin
        m_addr  <= m_base + 32'(m_beats) * 32'(AI);
        m_data  <= bus.wdata;
        m_beats <= m_beats + 1;
        m_since <= 1;
      end else if (m_since < 3) begin
        m_since <= m_since + 1;
      end
      if (exp_bvalid() && bus.bready) m_busy <= 1'b0;
    end
  end

  logic [31:0] obs_addr[$];
  logic [31:0] obs_data[$];
  int          obs_b = 0;

  always @(negedge clk) begin
    if (m_started) begin
      chk("awready", 64'(bus.awready), 64'(exp_awready()));
      chk("wready", 64'(bus.wready), 64'(exp_wready()));
      chk("bvalid", 64'(bus.bvalid), 64'(exp_bvalid()));
      chk("PSEL", 64'(bus.PSEL), 64'(m_since == 1 || m_since == 2));
      chk("PENABLE", 64'(bus.PENABLE), 64'(m_since == 2));
      chk("PWRITE", 64'(bus.PWRITE), 64'(m_since == 1 || m_since == 2));
      chk("PADDR", 64'(bus.PADDR), 64'(m_addr));
      chk("PWDATA", 64'(bus.PWDATA), 64'(m_data));
      if (bus.PSEL === 1'b1 && bus.PENABLE === 1'b0) begin
        obs_addr.push_back(bus.PADDR);
        obs_data.push_back(bus.PWDATA);
      end
      if (bus.bvalid === 1'b1 && bus.bready === 1'b1) obs_b++;
    end
  end

  task automatic lit(input string name, input int idx, input logic [31:0] ea,
                     input logic [31:0] ed);
    logic [63:0] a;
    logic [63:0] d;
    a = (idx < obs_addr.size()) ? 64'(obs_addr[idx]) : '1;
    d = (idx < obs_data.size()) ? 64'(obs_data[idx]) : '1;
    chk({name, "_paddr"}, a, 64'(ea));
    chk({name, "_pwdata"}, d, 64'(ed));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic aw_hs(input logic [31:0] a, input int gap);
    bit ok;
    for (int i = 0; i < gap; i++) begin
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'($urandom % 2);
      bus.wdata   = $urandom;
      tick();
    end
    bus.wvalid  = 1'b0;
    bus.awvalid = 1'b1;
    bus.awaddr  = a;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = bus.awready;
      tick();
    end
    bus.awvalid = 1'b0;
    bus.awaddr  = $urandom;
    chk("aw_wait", 64'(ok), 64'd1);
  endtask

  task automatic w_hs(input logic [31:0] d, input int gap);
    bit ok;
    for (int i = 0; i < gap; i++) begin
      bus.wvalid  = 1'b0;
      bus.wdata   = $urandom;
      bus.awvalid = 1'($urandom % 2);
      bus.awaddr  = $urandom;
      tick();
    end
    bus.wvalid = 1'b1;
    bus.wdata  = d;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = bus.wready;
      tick();
    end
    bus.awvalid = 1'b0;
    chk("w_wait", 64'(ok), 64'd1);
  endtask

  task automatic b_hs(input int bdel);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      bus.wvalid = 1'($urandom % 2);
      bus.wdata  = $urandom;
      @(negedge clk);
      ok = bus.bvalid;
      tick();
    end
    chk("b_wait", 64'(ok), 64'd1);
    for (int i = 0; i < bdel; i++) begin
      bus.awvalid = 1'($urandom % 2);
      bus.awaddr  = $urandom;
      tick();
    end
    bus.awvalid = 1'b0;
    bus.bready  = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = bus.bvalid;
      tick();
    end
    bus.bready = 1'b0;
    bus.wvalid = 1'b0;
    chk("b_hs_wait", 64'(ok), 64'd1);
  endtask

  task automatic run_burst(input logic [31:0] a, input logic [31:0] d[4], input int gmax,
                           input int bdel);
    aw_hs(a, 0);
    for (int i = 0; i < BL; i++) w_hs(d[i], (gmax == 0) ? 0 : int'($urandom_range(0, gmax)));
    b_hs(bdel);
  endtask

  logic [31:0] d1[4] = '{32'h12345678, 32'h2468acf0, 32'h369d0368, 32'h48d159e0};
  logic [31:0] d2[4] = '{32'h59e26af1, 32'h6af37c02, 32'h7c048d13, 32'h8d159e24};
  logic [31:0] d3[4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};

  initial begin
    int k;
    int b0;
    logic [31:0] rd[4];
    bus.awaddr  = '0;
    bus.awvalid = 1'b0;
    bus.wdata   = '0;
    bus.wvalid  = 1'b0;
    bus.bready  = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    // wvalid in IDLE must not be acknowledged
    for (int i = 0; i < 3; i++) begin
      bus.wvalid = 1'b1;
      bus.wdata  = $urandom;
      tick();
    end
    bus.wvalid = 1'b0;

    k = obs_addr.size();
    b0 = obs_b;
    run_burst(32'haabbccdd, d1, 0, 0);
    lit("b1_0", k + 0, 32'haabbccdd, 32'h12345678);
    lit("b1_1", k + 1, 32'haabbcce1, 32'h2468acf0);
    lit("b1_2", k + 2, 32'haabbcce5, 32'h369d0368);
    lit("b1_3", k + 3, 32'haabbcce9, 32'h48d159e0);
    chk("b1_bcount", 64'(obs_b - b0), 64'd1);

    k = obs_addr.size();
    run_burst(32'heeffaabb, d2, 2, 5);
    lit("b2_0", k + 0, 32'heeffaabb, 32'h59e26af1);
    lit("b2_1", k + 1, 32'heeffaabf, 32'h6af37c02);
    lit("b2_2", k + 2, 32'heeffaac3, 32'h7c048d13);
    lit("b2_3", k + 3, 32'heeffaac7, 32'h8d159e24);
    chk("b2_bcount", 64'(obs_b - b0), 64'd2);

    k = obs_addr.size();
    run_burst(32'hfffffff8, d3, 1, 1);
    lit("wrap_0", k + 0, 32'hfffffff8, 32'h11111111);
    lit("wrap_1", k + 1, 32'hfffffffc, 32'h22222222);
    lit("wrap_2", k + 2, 32'h00000000, 32'h33333333);
    lit("wrap_3", k + 3, 32'h00000004, 32'h44444444);

    // Reset after the second beat completes: burst aborted, no B response.
    k = obs_addr.size();
    b0 = obs_b;
    aw_hs(32'h00001000, 1);
    w_hs(d1[0], 0);
    w_hs(d1[1], 0);
    tick();
    tick();
    rst = 1'b1;
    bus.wvalid  = 1'b1;
    bus.awvalid = 1'b1;
    tick();
    rst = 1'b0;
    bus.wvalid  = 1'b0;
    bus.awvalid = 1'b0;
    repeat (4) tick();
    chk("abort_beats", 64'(obs_addr.size() - k), 64'd2);
    chk("abort_no_b", 64'(obs_b - b0), 64'd0);
    k = obs_addr.size();
    run_burst(32'h00002000, d2, 0, 0);
    lit("fresh_0", k + 0, 32'h00002000, 32'h59e26af1);
    lit("fresh_3", k + 3, 32'h0000200c, 32'h8d159e24);

    for (int n = 0; n < 25; n++) begin
      foreach (rd[j]) rd[j] = $urandom;
      aw_hs($urandom, int'($urandom_range(0, 3)));
      for (int i = 0; i < BL; i++) w_hs(rd[i], int'($urandom_range(0, 3)));
      b_hs(int'($urandom_range(0, 3)));
    end
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end
endmodule
